mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter for the single shared main memory behind the 16-bit CPU. It accepts cache-line fill requests from the instruction-fetch (IF) side and line fills or single-word write-throughs from the data (MEM) side. It issues one memory word per cycle to a fixed-latency pipelined memory and steers returning words back to the owning requester. It sits between the IF/MEM stage caches and the memory model.

## Interface
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `MEM_LAT`, 4: cycles from `mem_en` read issue to matching `mem_data_valid`.
- `LINE_WORDS`, 8: words per line. Line is 16 bytes; word index is 3 bits.

Ports:
- `clk`  in  1  Single clock.
- `rst`  in  1  Reset, asynchronous, active-low.
- `if_req`  in  1  IF line-fill request. Level.
- `if_addr`  in  ADDR_W  IF miss address.
- `if_grant`  out  1  IF owns memory.
- `if_data_valid`  out  1  `if_data` / `if_word_idx` valid this cycle.
- `if_data`  out  DATA_W  Returned word.
- `if_word_idx`  out  3  Word position within the line.
- `if_done`  out  1  One-cycle pulse: IF transaction complete.
- `d_req`, `d_wr`, `d_addr`, `d_wdata`  in  1/1/ADDR_W/DATA_W  Data-side request. `d_wr`=1 means single-word write.
- `d_grant`, `d_data_valid`, `d_data`, `d_word_idx`, `d_done`  out  Same meaning as the IF side.
- `mem_en`, `mem_wr`  out  1  Memory issue strobe and write select.
- `mem_addr`  out  ADDR_W  Memory address.
- `mem_wdata`  out  DATA_W  Write data.
- `mem_rdata`  in  DATA_W  Read data.
- `mem_data_valid`  in  1  Read data valid.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: requests are sampled only in this state.
  - `d_req` has fixed priority over `if_req`.
  - Latch owner, `d_wr`, `line_base = addr & ~16'hF`, and `d_wdata`.
  - Next state is WRITE if the data side wins with `d_wr`=1, else ISSUE.
- ISSUE: `mem_en`=1, `mem_wr`=0, `mem_addr = line_base + 2*issue_cnt`.
  - `issue_cnt` runs 0..7, one per cycle.
  - After the cycle with `issue_cnt`=7, go to DRAIN.
  - DRAIN is skipped if the 8th return coincides with the last issue cycle; that case never arises for `MEM_LAT`≥1.
- Returns (ISSUE or DRAIN): each `mem_data_valid` forwards `mem_rdata` to the owner's `*_data`.
  - Owner's `*_data_valid`=1 and `*_word_idx = recv_cnt`; `recv_cnt` then increments.
  - The 8th return also asserts owner `*_done` in the same cycle; next state is IDLE.
- WRITE: one cycle. `mem_en`=1, `mem_wr`=1, `mem_addr = d_addr`, `mem_wdata` = latched data, `d_done`=1. Next state is IDLE.
- Grant is registered: high from the cycle after acceptance through the done cycle. The non-owner's outputs stay 0.
- Requester must deassert `*_req` in the cycle after `*_done`. A request still high at the following IDLE edge starts a new transaction.
- `mem_data_valid` in IDLE or WRITE, or beyond 8 returns, is ignored.
- Address arithmetic is modulo 2^16. Low 4 bits of a fill address are ignored. Write address is used unmodified.

## Timing
- Reset (async, `rst`=0): state IDLE, counters 0, owner cleared. All outputs 0, including `*_data`.
- Reset mid-transaction aborts immediately. Memory returns still in flight after reset deasserts are ignored (arrive in IDLE).
- Fill latency: request sampled at edge k.
  - `mem_en` high in cycles k+1..k+8.
  - Data returns in cycles k+1+MEM_LAT..k+8+MEM_LAT.
  - `*_done` in cycle k+8+MEM_LAT (12 cycles after edge k for MEM_LAT=4).
- Write latency: `mem_en`/`mem_wr` and `d_done` both occur in cycle k+1.
- Back-to-back: at least one IDLE cycle separates transactions. Worst-case IF wait behind one D fill is 1+8+MEM_LAT+1 cycles.
- Simultaneous `if_req` and `d_req` in IDLE: D wins. IF is granted at the edge ending the next IDLE cycle, if `if_req` is still high.

## Structure
- Shared header `mem_defs.vh` holds:
  - State encodings: IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, WRITE=2'd3.
  - `LINE_WORDS`, line mask 16'hFFF0.
  - Owner encodings: OWN_IF=1'b0, OWN_D=1'b1.
- One sub-module, `word_counter`: 3-bit counter with enable, sync clear, and async active-low reset, with a terminal-count output. Instantiate it twice, for `issue_cnt` and `recv_cnt`.

## Test plan
- Reset: hold `rst`=0 with random requests → all outputs 0. Assert reset mid-fill at return 3 → FSM returns to IDLE, and later `mem_data_valid` pulses produce no `if_data_valid`.
- IF fill: `if_addr`=16'h1236 → `mem_addr` 16'h1230, 1232, …, 123E on consecutive cycles. With the model returning 16'hA000+idx, `if_data_valid` carries idx 0..7. `if_done` occurs 12 cycles after the request edge.
- D write: `d_req`=1, `d_wr`=1, `d_addr`=16'h0042, `d_wdata`=16'hBEEF → a single cycle with `mem_wr`=1, addr 16'h0042, data 16'hBEEF, and `d_done` in the same cycle.
- Simultaneous `if_req`, `d_req` fill at 16'h2000/16'h3000 → D line at 16'h3000 served first. IF is granted at the edge after the IDLE cycle following `d_done`. IF outputs stay 0 during the D fill.
- Wrap-around: `if_addr`=16'hFFF8 → addresses 16'hFFF0..16'hFFFE, no carry out.
- Sticky request: `if_req` held high after `if_done` → a second fill starts after one IDLE cycle. A spurious `mem_data_valid` during that IDLE cycle is ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM states, owner codes, line geometry.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StWrite = 2'd3
    } state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnD  = 1'b1
    } owner_e;

    localparam int unsigned LineWords = 8;
    localparam logic [15:0] LineMask  = 16'hFFF0;

endpackage

// File: rtl/mem_arbiter_word_counter.sv
// Small up-counter with enable, synchronous clear and terminal-count flag.
module word_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    // Count register: clear wins over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;
    assign tc  = &cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared main memory: IF line fills, D line fills and D word writes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned LINE_WORDS = LineWords
) (
    input  logic                          clk,
    input  logic                          rst,
    // Instruction-fetch side
    input  logic                          if_req,
    input  logic [ADDR_W-1:0]             if_addr,
    output logic                          if_grant,
    output logic                          if_data_valid,
    output logic [DATA_W-1:0]             if_data,
    output logic [$clog2(LINE_WORDS)-1:0] if_word_idx,
    output logic                          if_done,
    // Data side
    input  logic                          d_req,
    input  logic                          d_wr,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          d_grant,
    output logic                          d_data_valid,
    output logic [DATA_W-1:0]             d_data,
    output logic [$clog2(LINE_WORDS)-1:0] d_word_idx,
    output logic                          d_done,
    // Memory side
    output logic                          mem_en,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_data_valid
);

    localparam int unsigned          IdxW    = $clog2(LINE_WORDS);
    // Byte offset bits within a line (two bytes per word).
    localparam logic [ADDR_W-1:0]    OffMask = ADDR_W'(2 * LINE_WORDS - 1);
    // Only a zero-latency memory can deliver the last word during the last issue cycle.
    localparam bit                   SkipDrainOk = (MEM_LAT == 0);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [IdxW-1:0]     issue_cnt, recv_cnt;
    logic                issue_tc, recv_tc;
    logic                busy, fwd, last_ret;
    logic [ADDR_W-1:0]   line_base;

    assign busy      = (state_q != StIdle);
    // Returns count only while a fill is in flight; anything else is stray.
    assign fwd       = mem_data_valid && ((state_q == StIssue) || (state_q == StDrain));
    assign last_ret  = fwd && recv_tc;
    assign line_base = addr_q & ~OffMask;

    word_counter #(
        .W   (IdxW)
    ) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state_q == StIssue),
        .clr (state_q == StIdle),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    word_counter #(
        .W   (IdxW)
    ) u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .en  (fwd),
        .clr (state_q == StIdle),
        .cnt (recv_cnt),
        .tc  (recv_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture: owner, address and write data latched when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OwnIf;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if ((state_q == StIdle) && (d_req || if_req)) begin
            owner_q <= d_req ? OwnD : OwnIf;
            addr_q  <= d_req ? d_addr : if_addr;
            wdata_q <= d_wdata;
        end
    end

    // Next-state logic: D has fixed priority; requests are looked at only in idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (d_req) begin
                    state_d = d_wr ? StWrite : StIssue;
                end else if (if_req) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (SkipDrainOk && last_ret) begin
                    state_d = StIdle;
                end else if (issue_tc) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_ret) begin
                    state_d = StIdle;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: memory issue from state, returns steered to the owner only.
    always_comb begin
        if_grant      = 1'b0;
        if_data_valid = 1'b0;
        if_data       = '0;
        if_word_idx   = '0;
        if_done       = 1'b0;
        d_grant       = 1'b0;
        d_data_valid  = 1'b0;
        d_data        = '0;
        d_word_idx    = '0;
        d_done        = 1'b0;
        mem_en        = (state_q == StIssue) || (state_q == StWrite);
        mem_wr        = (state_q == StWrite);
        mem_addr      = '0;
        mem_wdata     = '0;

        if (state_q == StIssue) begin
            mem_addr = line_base + ADDR_W'({issue_cnt, 1'b0});
        end else if (state_q == StWrite) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end

        if (owner_q == OwnD) begin
            d_grant      = busy;
            d_data_valid = fwd;
            d_data       = fwd ? mem_rdata : '0;
            d_word_idx   = fwd ? recv_cnt : '0;
            d_done       = last_ret || (state_q == StWrite);
        end else begin
            if_grant      = busy;
            if_data_valid = fwd;
            if_data       = fwd ? mem_rdata : '0;
            if_word_idx   = fwd ? recv_cnt : '0;
            if_done       = last_ret;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MEM_LAT    = 4;
    localparam int LINE_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_grant, if_data_valid, if_done;
    logic [15:0] if_data;
    logic [2:0]  if_word_idx;
    logic        d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] d_addr = '0, d_wdata = '0;
    logic        d_grant, d_data_valid, d_done;
    logic [15:0] d_data;
    logic [2:0]  d_word_idx;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_data_valid = 1'b0;

    mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MEM_LAT       (MEM_LAT),
        .LINE_WORDS    (LINE_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_grant      (if_grant),
        .if_data_valid (if_data_valid),
        .if_data       (if_data),
        .if_word_idx   (if_word_idx),
        .if_done       (if_done),
        .d_req         (d_req),
        .d_wr          (d_wr),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_grant       (d_grant),
        .d_data_valid  (d_data_valid),
        .d_data        (d_data),
        .d_word_idx    (d_word_idx),
        .d_done        (d_done),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: one transaction at a time, described by its start cycle.
    bit          m_busy = 0, m_own_d = 0, m_write = 0;
    int          m_start = 0;
    logic [15:0] m_base = '0, m_addr = '0, m_wdata = '0;
    bit          m_if_done_last = 0, m_d_done_last = 0;

    bit          spur_en = 0, mem_mix = 0;
    bit          if_sticky = 0, d_sticky = 0;
    logic [15:0] pipe [int];

    // Observation log used by the directed literal checks.
    int          if_dv_cnt = 0, if_done_cnt = 0, d_done_cyc = 0, if_grant_cyc = 0;
    int          wr_cyc_log = 0;
    int          if_done_cyc_q[$];
    logic [15:0] iss_addr_q[$];
    logic [15:0] wr_addr_log = '0, wr_data_log = '0, if_first_data = '0;
    logic        if_grant_prev = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (mem_mix) return (a ^ 16'h5A5A) + 16'h0101;
        return 16'hA000 + {13'd0, a[3:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: fixed-latency read pipeline, plus optional stray valids while idle.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pipe.exists(cyc)) begin
            mem_data_valid = 1'b1;
            mem_rdata      = pipe[cyc];
            pipe.delete(cyc);
        end else if (spur_en && !m_busy) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 16'($urandom);
        end else begin
            mem_data_valid = 1'b0;
            mem_rdata      = 16'($urandom);
        end
    end

    // Compare process: model expectations vs DUT every cycle, then advance the model.
    always @(negedge clk) begin : compare
        int          t, idx;
        logic        e_g, e_dv, e_done, e_men, e_mwr;
        logic [15:0] e_data, e_maddr, e_mwd;
        logic [2:0]  e_idx;
        logic        is_if, is_d;

        e_g = 0; e_dv = 0; e_done = 0; e_men = 0; e_mwr = 0;
        e_data = '0; e_maddr = '0; e_mwd = '0; e_idx = '0;
        if (rst && m_busy) begin
            t   = cyc - m_start;
            e_g = 1;
            if (m_write) begin
                e_men = 1; e_mwr = 1; e_maddr = m_addr; e_mwd = m_wdata; e_done = 1;
            end else begin
                if (t < LINE_WORDS) begin
                    e_men   = 1;
                    e_maddr = m_base + 16'(2 * t);
                end
                if (t >= MEM_LAT && t < MEM_LAT + LINE_WORDS) begin
                    idx    = t - MEM_LAT;
                    e_dv   = 1;
                    e_idx  = 3'(idx);
                    e_data = mem_word(m_base + 16'(2 * idx));
                    e_done = (idx == LINE_WORDS - 1);
                end
            end
        end
        is_if = !m_own_d;
        is_d  = m_own_d;

        check("if_grant",      32'(if_grant),      32'(e_g && is_if));
        check("if_data_valid", 32'(if_data_valid), 32'(e_dv && is_if));
        check("if_data",       32'(if_data),       32'(is_if ? e_data : 16'h0));
        check("if_word_idx",   32'(if_word_idx),   32'(is_if ? e_idx : 3'h0));
        check("if_done",       32'(if_done),       32'(e_done && is_if));
        check("d_grant",       32'(d_grant),       32'(e_g && is_d));
        check("d_data_valid",  32'(d_data_valid),  32'(e_dv && is_d));
        check("d_data",        32'(d_data),        32'(is_d ? e_data : 16'h0));
        check("d_word_idx",    32'(d_word_idx),    32'(is_d ? e_idx : 3'h0));
        check("d_done",        32'(d_done),        32'(e_done && is_d));
        check("mem_en",        32'(mem_en),        32'(e_men));
        check("mem_wr",        32'(mem_wr),        32'(e_mwr));
        check("mem_addr",      32'(mem_addr),      32'(e_maddr));
        check("mem_wdata",     32'(mem_wdata),     32'(e_mwd));

        if (if_data_valid) begin
            if_dv_cnt++;
            if (if_word_idx == 3'd0) if_first_data = if_data;
        end
        if (if_done) begin
            if_done_cnt++;
            if_done_cyc_q.push_back(cyc);
        end
        if (d_done) d_done_cyc = cyc;
        if (if_grant && !if_grant_prev) if_grant_cyc = cyc;
        if_grant_prev = if_grant;
        if (mem_en) begin
            iss_addr_q.push_back(mem_addr);
            if (mem_wr) begin
                wr_addr_log = mem_addr;
                wr_data_log = mem_wdata;
                wr_cyc_log  = cyc;
            end else begin
                pipe[cyc + MEM_LAT] = mem_word(mem_addr);
            end
        end

        m_if_done_last = e_done && is_if;
        m_d_done_last  = e_done && is_d;
        if (!rst) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (m_write || (cyc - m_start) == MEM_LAT + LINE_WORDS - 1) m_busy = 0;
        end else if (d_req) begin
            m_busy = 1; m_own_d = 1; m_write = d_wr; m_addr = d_addr;
            m_base = d_addr & 16'hFFF0; m_wdata = d_wdata; m_start = cyc + 1;
        end else if (if_req) begin
            m_busy = 1; m_own_d = 0; m_write = 0; m_addr = if_addr;
            m_base = if_addr & 16'hFFF0; m_start = cyc + 1;
        end
    end

    // One cycle of stimulus; requesters drop their request the cycle after done unless sticky.
    task automatic tick();
        @(posedge clk);
        #2;
        if (m_if_done_last) begin
            if (if_sticky) if_sticky = 0;
            else if_req = 1'b0;
        end
        if (m_d_done_last) begin
            if (d_sticky) d_sticky = 0;
            else d_req = 1'b0;
        end
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while ((if_req || d_req || m_busy || pipe.num() != 0) && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c0, base_dv, base_done, n, first_done;

        // Reset held with random request activity.
        for (int i = 0; i < 6; i++) begin
            tick();
            if_req = 1'($urandom); if_addr = 16'($urandom);
            d_req  = 1'($urandom); d_wr = 1'($urandom); d_addr = 16'($urandom);
        end
        #1;
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_grants",   32'({if_grant, d_grant, mem_en}), 32'h0);
        if_req = 0; d_req = 0; d_wr = 0;
        tick();
        rst = 1'b1;
        tick();

        // IF fill at 0x1236.
        iss_addr_q.delete();
        if_addr = 16'h1236; if_req = 1'b1; c0 = cyc; base_dv = if_dv_cnt;
        wait_quiet(40, "if_fill_wait");
        check("if_fill_issues", 32'(iss_addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("if_fill_addr", 32'(iss_addr_q[i]), 32'h1230 + 32'(2 * i));
        check("if_fill_done_lat", 32'(if_done_cyc_q[$] - c0), 32'd12);
        check("if_fill_word0", 32'(if_first_data), 32'hA000);
        check("if_fill_returns", 32'(if_dv_cnt - base_dv), 32'd8);

        // D single-word write.
        iss_addr_q.delete();
        d_addr = 16'h0042; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1; c0 = cyc;
        wait_quiet(20, "d_write_wait");
        d_wr = 1'b0;
        check("d_write_issues", 32'(iss_addr_q.size()), 32'd1);
        check("d_write_addr", 32'(wr_addr_log), 32'h0042);
        check("d_write_data", 32'(wr_data_log), 32'hBEEF);
        check("d_write_cycle", 32'(wr_cyc_log - c0), 32'd1);
        check("d_write_done", 32'(d_done_cyc - c0), 32'd1);

        // Simultaneous requests: D fill first, IF after one idle cycle.
        iss_addr_q.delete();
        if_addr = 16'h2000; d_addr = 16'h3000; if_req = 1'b1; d_req = 1'b1; c0 = cyc;
        wait_quiet(80, "simul_wait");
        check("simul_issues", 32'(iss_addr_q.size()), 32'd16);
        check("simul_first_d", 32'(iss_addr_q[0]), 32'h3000);
        check("simul_then_if", 32'(iss_addr_q[8]), 32'h2000);
        check("simul_d_done", 32'(d_done_cyc - c0), 32'd12);
        check("simul_if_grant", 32'(if_grant_cyc - d_done_cyc), 32'd2);

        // Address wrap at the top of memory.
        iss_addr_q.delete();
        if_addr = 16'hFFF8; if_req = 1'b1;
        wait_quiet(40, "wrap_wait");
        check("wrap_first", 32'(iss_addr_q[0]), 32'hFFF0);
        check("wrap_last", 32'(iss_addr_q[7]), 32'hFFFE);

        // Sticky request with a stray return in the idle gap.
        spur_en = 1; iss_addr_q.delete();
        base_done = if_done_cnt; base_dv = if_dv_cnt;
        if_addr = 16'h4444; if_sticky = 1; if_req = 1'b1;
        wait_quiet(80, "sticky_wait");
        spur_en = 0;
        check("sticky_fills", 32'(if_done_cnt - base_done), 32'd2);
        check("sticky_returns", 32'(if_dv_cnt - base_dv), 32'd16);
        first_done = if_done_cyc_q[if_done_cyc_q.size() - 2];
        check("sticky_gap", 32'(if_done_cyc_q[$] - first_done), 32'd13);

        // Reset in the middle of a fill, after the third return.
        if_addr = 16'h5670; if_req = 1'b1; base_dv = if_dv_cnt; n = 0;
        while (if_dv_cnt < base_dv + 3 && n < 40) begin
            tick();
            n++;
        end
        check("midreset_reach", 32'(n < 40), 32'd1);
        rst = 1'b0; if_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        repeat (10) tick();
        check("midreset_no_data", 32'(if_dv_cnt - base_dv), 32'd3);
        wait_quiet(20, "midreset_wait");

        // Randomized traffic.
        mem_mix = 1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (i % 100 == 0) spur_en = 1'($urandom_range(0, 1));
            if (!if_req && !m_if_done_last && $urandom_range(0, 3) == 0) begin
                if_addr = 16'($urandom); if_sticky = ($urandom_range(0, 3) == 0); if_req = 1'b1;
            end
            if (!d_req && !m_d_done_last && $urandom_range(0, 3) == 0) begin
                d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = 1'($urandom);
                d_sticky = ($urandom_range(0, 3) == 0); d_req = 1'b1;
            end
        end
        if_sticky = 0; d_sticky = 0;
        wait_quiet(200, "final_drain");
        spur_en = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
